// File: rtl/alu_result_stage.sv
// Registered 2-entry result buffer behind the ALU op-select muxes: it captures the result and
// derives its flags at push, then presents them through a valid/ready handshake with a registered in_ready.
module alu_result_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [2:0]       in_op,
  input  logic             in_carry,
  input  logic             in_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [2:0]       out_op,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry,
  output logic             out_ovf
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [2:0]       op;
    logic             zero;
    logic             neg;
    logic             carry;
    logic             ovf;
  } entry_t;

  entry_t [1:0] mem;
  entry_t       new_entry, head;
  logic         rd_ptr, wr_ptr;
  logic [1:0]   count, count_nxt;
  logic         ready_q;
  logic         push, pop, arith;

  assign in_ready  = ready_q;
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & ready_q;
  assign pop       = out_valid & out_ready;
  assign arith     = (in_op <= 3'd1);

  always_comb begin
    new_entry        = '0;
    new_entry.result = in_result;
    new_entry.op     = in_op;
    new_entry.zero   = ~|in_result;
    new_entry.neg    = in_result[WIDTH-1];
    new_entry.carry  = in_carry & arith;
    new_entry.ovf    = in_ovf & arith;
  end

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem     <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count   <= 2'd0;
      ready_q <= 1'b0;
    end else begin
      if (push) mem[wr_ptr] <= new_entry;
      wr_ptr  <= wr_ptr ^ push;
      rd_ptr  <= rd_ptr ^ pop;
      count   <= count_nxt;
      ready_q <= (count_nxt < 2'd2);
    end
  end

  // When empty, the slot behind rd_ptr still holds the last popped entry (zeros after reset).
  assign head       = (count == 2'd0) ? mem[~rd_ptr] : mem[rd_ptr];
  assign out_result = head.result;
  assign out_op     = head.op;
  assign out_zero   = head.zero;
  assign out_neg    = head.neg;
  assign out_carry  = head.carry;
  assign out_ovf    = head.ovf;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: expected entries are queued at push and compared at pop.
module tb_alu_result_stage;
  localparam int WIDTH = 32;

  typedef struct {
    logic [WIDTH-1:0] result;
    logic [2:0]       op;
    logic             zero, neg, carry, ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0, in_carry = 1'b0, in_ovf = 1'b0, out_ready = 1'b0;
  logic [WIDTH-1:0] in_result = '0;
  logic [2:0]       in_op = '0;
  logic             in_ready, out_valid, out_zero, out_neg, out_carry, out_ovf;
  logic [WIDTH-1:0] out_result;
  logic [2:0]       out_op;

  int   n_cmp = 0, n_err = 0;
  exp_t q[$];
  exp_t last;
  bit   armed = 0;

  alu_result_stage #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_op(in_op), .in_carry(in_carry), .in_ovf(in_ovf),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_op(out_op),
    .out_zero(out_zero), .out_neg(out_neg), .out_carry(out_carry), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_head(input string tag, input exp_t e);
    chk({tag, ".result"}, 64'(out_result), 64'(e.result));
    chk({tag, ".op"},     64'(out_op),     64'(e.op));
    chk({tag, ".zero"},   64'(out_zero),   64'(e.zero));
    chk({tag, ".neg"},    64'(out_neg),    64'(e.neg));
    chk({tag, ".carry"},  64'(out_carry),  64'(e.carry));
    chk({tag, ".ovf"},    64'(out_ovf),    64'(e.ovf));
  endtask

  task automatic drive(input logic v, input logic r, input logic [WIDTH-1:0] res,
                       input logic [2:0] op, input logic c, input logic o);
    in_valid = v; out_ready = r; in_result = res; in_op = op; in_carry = c; in_ovf = o;
  endtask

  // Called after a falling edge with inputs set: checks the current cycle, books the
  // transfers that the next rising edge will perform, then advances one cycle.
  task automatic tick();
    exp_t e;
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(armed && q.size() < 2));
    if (q.size() != 0) chk_head("head", q[0]);
    else               chk_head("idle_hold", last);
    if (out_valid && out_ready && q.size() != 0) last = q.pop_front();
    if (in_valid && in_ready) begin
      e.result = in_result; e.op = in_op;
      e.zero = (in_result == '0); e.neg = in_result[WIDTH-1];
      e.carry = in_carry && (in_op == 3'd0 || in_op == 3'd1);
      e.ovf   = in_ovf   && (in_op == 3'd0 || in_op == 3'd1);
      q.push_back(e);
    end
    @(posedge clk);
    if (rst_n) armed = 1;
    @(negedge clk);
  endtask

  task automatic clear_model();
    q.delete();
    last = '{default: '0};
    armed = 0;
  endtask

  initial begin
    clear_model();
    // reset with in_valid asserted
    drive(1, 1, 32'hDEAD_BEEF, 3'd0, 1, 1);
    @(negedge clk); @(negedge clk);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd0);
    chk("rst.out_result", 64'(out_result), 64'd0);
    drive(0, 0, '0, 3'd0, 0, 0);
    rst_n = 1'b1;
    tick();
    chk("rst.ready_after_edge", 64'(in_ready), 64'd1);

    // ADD wrap to zero with carry
    drive(1, 0, 32'h0, 3'd0, 1, 0); tick();
    drive(0, 1, '0, 3'd0, 0, 0);
    chk("add.zero", 64'(out_zero), 64'd1);
    chk("add.carry", 64'(out_carry), 64'd1);
    chk("add.neg", 64'(out_neg), 64'd0);
    tick();

    // AND masks carry/overflow
    drive(1, 0, 32'h8000_0000, 3'd4, 1, 1); tick();
    drive(0, 1, '0, 3'd0, 0, 0);
    chk("and.carry", 64'(out_carry), 64'd0);
    chk("and.ovf", 64'(out_ovf), 64'd0);
    chk("and.neg", 64'(out_neg), 64'd1);
    chk("and.zero", 64'(out_zero), 64'd0);
    tick();

    // Stall: A, B fill; C refused
    drive(1, 0, 32'h11, 3'd2, 0, 0); tick();
    drive(1, 0, 32'h22, 3'd7, 0, 0); tick();
    drive(1, 0, 32'h33, 3'd1, 1, 1);
    chk("full.in_ready", 64'(in_ready), 64'd0);
    tick(); tick();
    drive(0, 1, '0, 3'd0, 0, 0);
    chk("full.head_A", 64'(out_result), 64'h11);
    tick();
    chk("full.head_B", 64'(out_result), 64'h22);
    chk("full.ready_freed", 64'(in_ready), 64'd1);
    tick(); tick();
    chk("empty.hold_B", 64'(out_result), 64'h22);

    // count=1, simultaneous push and pop
    drive(1, 0, 32'd5, 3'd0, 0, 0); tick();
    drive(1, 1, 32'd6, 3'd1, 0, 1); tick();
    drive(0, 0, '0, 3'd0, 0, 0);
    chk("pp.result", 64'(out_result), 64'd6);
    chk("pp.ovf", 64'(out_ovf), 64'd1);
    chk("pp.in_ready", 64'(in_ready), 64'd1);
    tick();
    drive(0, 1, '0, 3'd0, 0, 0); tick();

    // Fill, then async reset mid-cycle
    drive(1, 0, 32'hA1, 3'd3, 0, 0); tick();
    drive(1, 0, 32'hA2, 3'd5, 0, 0); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst.out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst.in_ready", 64'(in_ready), 64'd0);
    chk("mid_rst.out_result", 64'(out_result), 64'd0);
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, '0, 3'd0, 0, 0); tick();
    drive(1, 0, 32'h77, 3'd6, 1, 1); tick();
    drive(0, 0, '0, 3'd0, 0, 0);
    chk("post_rst.result", 64'(out_result), 64'h77);
    tick();
    drive(0, 1, '0, 3'd0, 0, 0); tick();
    chk("post_rst.alone", 64'(out_valid), 64'd0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      logic [WIDTH-1:0] r;
      r = (($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom));
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0), r,
            3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
      tick();
    end
    drive(0, 1, '0, 3'd0, 0, 0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
